// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared types and default constants for the float scoreboard.
//   slot_t : one pipeline-stage entry {valid, wen, rd, lat}.
//   rd/lat fields are sized for the widest legal configuration
//   (up to 256 registers, DEPTH up to 15) so the struct can live in a package.
package fpu_pkg;
    localparam int NREG_DEF  = 32;
    localparam int DEPTH_DEF = 6;
    localparam int NSRC_DEF  = 3;
    localparam int KILL_DEF  = 1;

    localparam int RD_W  = 8;
    localparam int LAT_W = 4;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [RD_W-1:0]  rd;
        logic [LAT_W-1:0] lat;
    } slot_t;
endpackage

// File: rtl/fpu_sb_match.sv
// fpu_sb_match -- hazard check for one source operand against all stages.
//   slots       : stage entries 1..DEPTH (stage 1 = youngest)
//   src, src_use: source register and whether it is actually read
//   issue_valid : an instruction is presented
//   stall       : this source blocks issue
//   sel         : one-hot operand select (bit 0 = register file, bit s = stage s)
// Macro FPU_SB_FWD_EN: when defined, results are forwarded from the pipeline;
// otherwise any in-flight writer of the source stalls issue.
module fpu_sb_match
    import fpu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 5
) (
    input  slot_t [DEPTH:1] slots,
    input  logic [AW-1:0]   src,
    input  logic            src_use,
    input  logic            issue_valid,
    output logic            stall,
    output logic [DEPTH:0]  sel
);
`ifdef FPU_SB_FWD_EN
    logic             hit;
    logic [LAT_W-1:0] hit_stage;
    logic [LAT_W-1:0] hit_lat;

    // Scan old to young so the youngest match is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_stage = '0;
        hit_lat   = '0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (slots[s].valid && slots[s].wen && slots[s].rd == RD_W'(src)) begin
                hit       = 1'b1;
                hit_stage = LAT_W'(s);
                hit_lat   = slots[s].lat;
            end
        end
    end

    // The consumer would pick up the stage-(s+1) result next cycle; that is
    // only legal once the producer's latency has been reached.
    assign stall = issue_valid & src_use & hit &
                   ((LAT_W+1)'(hit_stage) + (LAT_W+1)'(1) < (LAT_W+1)'(hit_lat));

    // A youngest match at DEPTH is being written this cycle, so the register
    // file already holds it by the time the operand is read.
    always_comb begin
        sel = (DEPTH+1)'(1);
        if (src_use && hit && int'(hit_stage) < DEPTH)
            sel = (DEPTH+1)'(1) << (hit_stage + LAT_W'(1));
    end
`else
    logic busy;
    logic unused_fields;

    // Stage DEPTH is excluded: that write reaches the operand via write-through.
    always_comb begin
        busy = 1'b0;
        for (int s = 1; s < DEPTH; s++)
            if (slots[s].valid && slots[s].wen && slots[s].rd == RD_W'(src))
                busy = 1'b1;
    end

    always_comb begin
        unused_fields = ^slots[DEPTH];
        for (int s = 1; s < DEPTH; s++)
            unused_fields = unused_fields ^ (^slots[s].lat);
    end

    assign stall = issue_valid & src_use & busy;
    assign sel   = (DEPTH+1)'(1);
`endif
endmodule

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard -- in-order float pipeline scoreboard with fixed write-back stage.
//   clk, rst              : clock, synchronous active-high reset
//   issue_valid/wen/rd/lat: presented instruction and its result latency
//   src_addr, src_use     : NSRC source registers (source i at [i*AW +: AW])
//   flush                 : kill presented instruction and stages 1..KILL
//   stall                 : combinational, presented instruction not accepted
//   fwd_sel               : registered one-hot operand select per source
//   wb_valid, wb_rd       : registered register-file write port
// Macro FPU_SB_FWD_EN enables result forwarding (see fpu_sb_match).
module fpu_scoreboard
    import fpu_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NSRC  = NSRC_DEF,
    parameter int KILL  = KILL_DEF,
    localparam int AW   = $clog2(NREG),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic                        issue_wen,
    input  logic [AW-1:0]               issue_rd,
    input  logic [LW-1:0]               issue_lat,
    input  logic [NSRC*AW-1:0]          src_addr,
    input  logic [NSRC-1:0]             src_use,
    input  logic                        flush,
    output logic                        stall,
    output logic [NSRC*(DEPTH+1)-1:0]   fwd_sel,
    output logic                        wb_valid,
    output logic [AW-1:0]               wb_rd
);
    slot_t [DEPTH:1]              slots;
    slot_t [DEPTH:1]              slots_d;
    logic  [NSRC-1:0]             stall_term;
    logic  [NSRC-1:0][DEPTH:0]    sel;
    logic  [NSRC-1:0][DEPTH:0]    sel_d;
    logic  [NSRC-1:0][DEPTH:0]    sel_rf;
    logic  [LAT_W-1:0]            lat_c;
    logic                         accept;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fpu_sb_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
            .slots       (slots),
            .src         (src_addr[i*AW +: AW]),
            .src_use     (src_use[i]),
            .issue_valid (issue_valid),
            .stall       (stall_term[i]),
            .sel         (sel[i])
        );
    end

    assign stall  = |stall_term;
    assign accept = issue_valid & ~stall & ~flush;

    always_comb begin
        if (issue_lat == '0)             lat_c = LAT_W'(1);
        else if (int'(issue_lat) > DEPTH) lat_c = LAT_W'(DEPTH);
        else                             lat_c = LAT_W'(issue_lat);
    end

    // Shift register of stage entries; flush clears entries leaving stages 1..KILL.
    always_comb begin
        slots_d[1] = '0;
        if (accept) begin
            slots_d[1].valid = 1'b1;
            slots_d[1].wen   = issue_wen;
            slots_d[1].rd    = RD_W'(issue_rd);
            slots_d[1].lat   = lat_c;
        end
        for (int s = 2; s <= DEPTH; s++) begin
            slots_d[s] = slots[s-1];
            if (flush && (s - 1) <= KILL)
                slots_d[s].valid = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++)
            sel_rf[i] = (DEPTH+1)'(1);
        sel_d = (issue_valid && !stall) ? sel : sel_rf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            fwd_sel  <= sel_rf;
        end else begin
            slots    <= slots_d;
            wb_valid <= slots_d[DEPTH].valid & slots_d[DEPTH].wen;
            wb_rd    <= slots_d[DEPTH].rd[AW-1:0];
            fwd_sel  <= sel_d;
        end
    end
endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard -- directed plus random checks of fpu_scoreboard against a
// list-of-instructions reference model (stage = cycles since issue).
module tb_fpu_scoreboard;
    localparam int NREG  = 32;
    localparam int DEPTH = 6;
    localparam int NSRC  = 3;
    localparam int KILL  = 1;
    localparam int AW    = $clog2(NREG);
    localparam int LW    = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       issue_valid;
    logic                       issue_wen;
    logic [AW-1:0]              issue_rd;
    logic [LW-1:0]              issue_lat;
    logic [NSRC*AW-1:0]         src_addr;
    logic [NSRC-1:0]            src_use;
    logic                       flush;
    logic                       stall;
    logic [NSRC*(DEPTH+1)-1:0]  fwd_sel;
    logic                       wb_valid;
    logic [AW-1:0]              wb_rd;

    fpu_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .NSRC(NSRC), .KILL(KILL)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src_addr(src_addr),
        .src_use(src_use), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        bit wen;
        int lat;
        int ic;
    } ent_t;

    ent_t q[$];
    int   now = 0;
    int   errors = 0;
    int   checks = 0;
    bit   last_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h cycle=%0d", tag, got, exp, now);
        end
    endtask

    task automatic set_in(input bit v, input bit w, input int rd, input int lat,
                          input int s0, input int s1, input int s2,
                          input int use_m, input bit fl);
        issue_valid = v;
        issue_wen   = w;
        issue_rd    = AW'(rd);
        issue_lat   = LW'(lat);
        src_addr    = {AW'(s2), AW'(s1), AW'(s0)};
        src_use     = NSRC'(use_m);
        flush       = fl;
    endtask

    // One clock: check stall, advance the model, check registered outputs.
    task automatic cycle();
        bit exp_stall;
        logic [NSRC-1:0][DEPTH:0] exp_sel;
        logic [NSRC-1:0][DEPTH:0] rf_sel;
        bit was_rst;
        bit exp_wbv;
        int exp_wbrd;
        int st, best, bl, l;
        bit anyb;
        #1;
        exp_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            rf_sel[i]  = (DEPTH+1)'(1);
            exp_sel[i] = (DEPTH+1)'(1);
            best = -1; bl = 0; anyb = 1'b0;
            if (issue_valid && src_use[i]) begin
                foreach (q[k]) begin
                    st = now - q[k].ic;
                    if (q[k].wen && q[k].rd == int'(src_addr[i*AW +: AW]) && st >= 1 && st <= DEPTH) begin
                        if (best < 0 || st < best) begin best = st; bl = q[k].lat; end
                        if (st <= DEPTH - 1) anyb = 1'b1;
                    end
                end
            end
`ifdef FPU_SB_FWD_EN
            if (best > 0 && best + 1 < bl) exp_stall = 1'b1;
            if (best > 0 && best < DEPTH) begin
                exp_sel[i] = '0;
                exp_sel[i][best+1] = 1'b1;
            end
`else
            if (anyb) exp_stall = 1'b1;
`endif
        end
        if (!issue_valid || exp_stall) exp_sel = rf_sel;
        chk("stall", 64'(stall), 64'(exp_stall));
        last_stall = exp_stall;

        was_rst = rst;
        if (rst) begin
            q.delete();
        end else begin
            if (flush)
                for (int k = q.size() - 1; k >= 0; k--) begin
                    st = now - q[k].ic;
                    if (st >= 1 && st <= KILL) q.delete(k);
                end
            if (issue_valid && !exp_stall && !flush) begin
                l = (issue_lat == 0) ? 1 : (int'(issue_lat) > DEPTH ? DEPTH : int'(issue_lat));
                q.push_back('{rd: int'(issue_rd), wen: issue_wen, lat: l, ic: now});
            end
        end

        @(posedge clk);
        now++;
        #1;
        for (int k = q.size() - 1; k >= 0; k--)
            if (now - q[k].ic > DEPTH) q.delete(k);
        exp_wbv = 1'b0; exp_wbrd = 0;
        foreach (q[k])
            if (now - q[k].ic == DEPTH && q[k].wen) begin exp_wbv = 1'b1; exp_wbrd = q[k].rd; end
        if (was_rst) exp_sel = rf_sel;
        chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
        if (exp_wbv || was_rst) chk("wb_rd", 64'(wb_rd), 64'(exp_wbrd));
        chk("fwd_sel", 64'(fwd_sel), 64'(exp_sel));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    // Present a consumer until it is accepted (bounded).
    task automatic consume(input int src);
        int n = 0;
        do begin
            set_in(1, 0, 0, 1, src, 0, 0, 1, 0);
            cycle();
            n++;
        end while (last_stall && n < 12);
        checks++;
        assert (!last_stall) else begin
            errors++;
            $error("FAIL consume_timeout got=stalled want=accepted src=%0d", src);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        idle(2);

        // lat=3 producer then immediate consumer
        set_in(1, 1, 5, 3, 0, 0, 0, 0, 0); cycle();
        consume(5);
        idle(DEPTH + 1);

        // lat=1 producer, consumer forwards from stage 1, write-back at DEPTH
        set_in(1, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        consume(2);
        idle(DEPTH + 1);

        // two writers of f7; the younger, slower one governs
        set_in(1, 1, 7, 1, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 7, 5, 0, 0, 0, 0, 0); cycle();
        consume(7);
        idle(DEPTH + 1);

        // flush kills stage 1 and the presented instruction; stage 2 survives
        set_in(1, 1, 1, 2, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 3, 2, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 4, 2, 0, 0, 0, 0, 1); cycle();
        idle(DEPTH + 1);

        // latency clamp boundaries: 0 and above DEPTH
        set_in(1, 1, 9, 0, 0, 0, 0, 0, 0); cycle();
        consume(9);
        set_in(1, 1, 10, 7, 0, 0, 0, 0, 0); cycle();
        consume(10);
        idle(DEPTH + 1);

        // reset with entries in flight discards their writes
        set_in(1, 1, 11, 2, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 12, 2, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 13, 2, 0, 0, 0, 0, 0); cycle();
        rst = 1'b1;
        set_in(1, 1, 14, 2, 0, 0, 0, 0, 0); cycle();
        rst = 1'b0;
        idle(DEPTH + 1);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(DEPTH + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_scoreboard.md
FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the number of float registers; AW = $clog2(NREG).
REQ-002 SHALL have parameter DEPTH, default 6, meaning the write-back stage index; valid range 2..15; LW = $clog2(DEPTH+1).
REQ-003 SHALL have parameter NSRC, default 3, meaning the number of source operands per instruction.
REQ-004 SHALL have parameter KILL, default 1, meaning flush invalidates stages 1..KILL; valid range 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port issue_valid, input, 1 bit: a decoded instruction is presented.
REQ-008 SHALL have port issue_wen, input, 1 bit: the instruction writes a float register.
REQ-009 SHALL have port issue_rd, input, AW bits: destination register.
REQ-010 SHALL have port issue_lat, input, LW bits: stage at which the result becomes valid.
REQ-011 SHALL have port src_addr, input, NSRC*AW bits: source registers, source i in bits [i*AW +: AW].
REQ-012 SHALL have port src_use, input, NSRC bits: the source is actually read.
REQ-013 SHALL have port flush, input, 1 bit: kill the presented instruction and young in-flight entries.
REQ-014 SHALL have port stall, output, 1 bit, combinational: the presented instruction is not accepted this cycle.
REQ-015 SHALL have port fwd_sel, output, NSRC*(DEPTH+1) bits, registered, one-hot per source: bit 0 selects the register file; bit s selects the stage-s result.
REQ-016 SHALL have port wb_valid, output, 1 bit, registered: register write enable.
REQ-017 SHALL have port wb_rd, output, AW bits, registered: register write address.

Function
REQ-018 SHALL hold one slot per stage 1..DEPTH; each slot holds {valid, wen, rd, lat}.
REQ-019 SHALL load stage 1 with the instruction when issue_valid & ~stall & ~flush; otherwise stage 1 SHALL load invalid.
REQ-020 SHALL shift every slot from stage s to stage s+1 each cycle; the stage-DEPTH entry then retires.
REQ-021 SHALL clamp issue_lat: 0 is treated as 1; values above DEPTH are treated as DEPTH.
REQ-022 SHALL drive wb_valid = valid & wen of the stage-DEPTH slot and wb_rd = its rd; an instruction accepted at cycle t writes back at cycle t+DEPTH.
REQ-023 SHALL consider only the youngest valid, wen entry whose rd equals src_addr[i], for each source with src_use[i] = 1 (smallest stage s).
REQ-024 SHALL assert stall if, for any such source match, s+1 < lat; older ready matches SHALL NOT mask a younger unready one.
REQ-025 SHALL, with no stall, register fwd_sel for source i as bit s+1 of the youngest match; with no match or src_use[i] = 0, bit 0.
REQ-026 SHALL ignore issue_valid = 0: stall = 0 and fwd_sel = bit 0.
REQ-027 SHALL, on flush, invalidate stages 1..KILL and suppress acceptance; stall is still computed as normal.
REQ-028 SHALL perform no WAW check: write-back order equals issue order because all entries retire at DEPTH.

Reset
REQ-029 SHALL, when rst = 1 at a clock edge, invalidate all slots, clear wb_valid and wb_rd to 0, and set fwd_sel to bit 0 for every source.
REQ-030 SHALL give rst priority over issue and flush in the same cycle; a reset mid-operation discards in-flight writes.

Configuration
REQ-031 SHALL, with macro FPU_SB_FWD_EN defined, implement forwarding per REQ-024/025.
REQ-032 SHALL, without FPU_SB_FWD_EN, stall while any valid, wen entry in stages 1..DEPTH-1 matches a used source, and hold fwd_sel constantly at bit 0; a match at DEPTH relies on register-file write-through.

Structure
REQ-033 SHALL place the slot struct typedef and the default parameter constants in shared package fpu_pkg.
REQ-034 SHALL implement the per-source youngest-match search and stall term as sub-module fpu_sb_match, instantiated NSRC times.

Verification (DEPTH=6, NSRC=3, FWD_EN defined)
REQ-035 SHALL check: reset, then an idle cycle -> wb_valid=0, fwd_sel = 0x01 on each source, stall=0.
REQ-036 SHALL check: lat=3 write to f5 at c0, then a consumer reading f5 at c1 -> stall=1 at c1, accepted at c2, fwd_sel src0 = bit 3 at c3.
REQ-037 SHALL check: lat=1 write to f2 at c0, consumer at c1 -> no stall, fwd_sel = bit 2 at c2; wb_valid=1 with wb_rd=2 at c6.
REQ-038 SHALL check: f7 written with lat=1 at c0 and lat=5 at c1, consumer at c2 -> stall until the younger entry is ready (accepted at c5, fwd_sel = bit 5).
REQ-039 SHALL check: flush while an instruction is presented and stage 1 is valid -> neither entry produces wb_valid; older entries retire unchanged.
REQ-040 SHALL check: rst asserted with 3 entries in flight -> wb_valid stays 0 for the following DEPTH cycles.
